// File: rtl/usart_tx_if.sv
// rtl/usart_tx_if.sv - IO-bus write/read signals of the USART transmitter
interface usart_tx_if;
  logic [7:0] write_data;
  logic       UDR_write_enable;
  logic       UCSRA_write_enable;
  logic       UCSRB_write_enable;
  logic       UBRRL_write_enable;
  logic [7:0] UCSRA_output;
  logic [7:0] UCSRB_output;
  logic [7:0] UBRRL_output;

  // Memory-map side: drives writes, reads register images
  modport master (
    output write_data, UDR_write_enable, UCSRA_write_enable,
           UCSRB_write_enable, UBRRL_write_enable,
    input  UCSRA_output, UCSRB_output, UBRRL_output
  );

  // Peripheral side
  modport slave (
    input  write_data, UDR_write_enable, UCSRA_write_enable,
           UCSRB_write_enable, UBRRL_write_enable,
    output UCSRA_output, UCSRB_output, UBRRL_output
  );
endinterface

// File: rtl/usart_tx.sv
// rtl/usart_tx.sv - 8N1 USART transmitter with double-buffered UDR (optional U2X via USART_TX_U2X_EN)
module usart_tx #(
  parameter int         OVERSAMPLE  = 16,
  parameter logic [7:0] UCSRA_RESET = 8'h20
) (
  input  logic         clk,
  input  logic         reset_n,
  usart_tx_if.slave    bus,
  output logic         TXD,
  output logic         udre_irq,
  output logic         txc_irq,
  output logic         tx_busy
);

  // Timer wide enough for OVERSAMPLE*256 clocks per bit
  localparam int TW = $clog2(OVERSAMPLE * 256 + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    buf_q, buf_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          txd_q, txd_d;
  logic          udre_q, udre_d;
  logic          txc_q, txc_d;
  logic          u2x_q, u2x_d;
  logic [7:0]    ucsrb_q, ucsrb_d;
  logic [7:0]    ubrrl_q, ubrrl_d;

  logic          txen;
  logic          tick;
  logic          load_ok;
  logic          load;
  logic          frame_done;
  logic          udr_accept;
  logic [TW-1:0] os_eff;
  logic [TW-1:0] period;

  // Shared decode: bit-boundary tick, byte-load and frame-end conditions, current bit period
  always_comb begin
    txen       = ucsrb_q[3];
    tick       = (timer_q == '0);
    load_ok    = txen & ~udre_q;
    load       = ((state_q == IDLE) & load_ok) | ((state_q == STOP) & tick & load_ok);
    frame_done = (state_q == STOP) & tick & ~load_ok;
    udr_accept = bus.UDR_write_enable & udre_q;
    os_eff     = u2x_q ? TW'(OVERSAMPLE / 2) : TW'(OVERSAMPLE);
    period     = os_eff * ({{(TW-8){1'b0}}, ubrrl_q} + TW'(1));
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (load_ok) state_d = START;
      START: if (tick) state_d = DATA;
      DATA:  if (tick && idx_q == 3'd7) state_d = STOP;
      STOP:  if (tick) state_d = load_ok ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: shifter, bit timer, TXD and status bits
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    txd_d   = txd_q;
    timer_d = timer_q;
    buf_d   = buf_q;
    udre_d  = udre_q;
    txc_d   = txc_q;
    ucsrb_d = ucsrb_q;
    ubrrl_d = ubrrl_q;

    if (load) begin
      shift_d = buf_q;
      txd_d   = 1'b0;
      timer_d = period - TW'(1);
    end else if (state_q == IDLE || frame_done) begin
      txd_d   = 1'b1;
      timer_d = '0;
    end else if (tick) begin
      // Every other bit boundary reloads with the period sampled now, so UBRRL/U2X changes land on the next bit
      timer_d = period - TW'(1);
      case (state_q)
        START: begin
          idx_d = 3'd0;
          txd_d = shift_q[0];
        end
        DATA: begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            txd_d = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end
        default: txd_d = 1'b1;
      endcase
    end else begin
      timer_d = timer_q - TW'(1);
    end

    // Loading empties the buffer; a write is only possible when it is already empty
    if (load)            udre_d = 1'b1;
    else if (udr_accept) udre_d = 1'b0;
    if (udr_accept)      buf_d  = bus.write_data;

    // Frame completion wins over a simultaneous write-one-to-clear
    if (frame_done)                                   txc_d = 1'b1;
    else if (bus.UCSRA_write_enable && bus.write_data[6]) txc_d = 1'b0;

    if (bus.UCSRB_write_enable) ucsrb_d = bus.write_data;
    if (bus.UBRRL_write_enable) ubrrl_d = bus.write_data;
  end

  // Double-speed bit is only writable when the feature is built in
`ifdef USART_TX_U2X_EN
  always_comb u2x_d = bus.UCSRA_write_enable ? bus.write_data[1] : u2x_q;
`else
  always_comb u2x_d = 1'b0;
`endif

  // Datapath and register-file storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q   <= 8'h00;
      shift_q <= 8'h00;
      idx_q   <= 3'd0;
      timer_q <= '0;
      txd_q   <= 1'b1;
      udre_q  <= UCSRA_RESET[5];
      txc_q   <= UCSRA_RESET[6];
`ifdef USART_TX_U2X_EN
      u2x_q   <= UCSRA_RESET[1];
`else
      u2x_q   <= 1'b0;
`endif
      ucsrb_q <= 8'h00;
      ubrrl_q <= 8'h00;
    end else begin
      buf_q   <= buf_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      txd_q   <= txd_d;
      udre_q  <= udre_d;
      txc_q   <= txc_d;
      u2x_q   <= u2x_d;
      ucsrb_q <= ucsrb_d;
      ubrrl_q <= ubrrl_d;
    end
  end

  // FSM outputs, interrupt requests and IO read images
  always_comb begin
    TXD              = txd_q;
    tx_busy          = (state_q != IDLE);
    udre_irq         = udre_q & ucsrb_q[5];
    txc_irq          = txc_q & ucsrb_q[6];
    bus.UCSRA_output = {1'b0, txc_q, udre_q, 3'b000, u2x_q, 1'b0};
    bus.UCSRB_output = ucsrb_q;
    bus.UBRRL_output = ubrrl_q;
  end

endmodule

// File: doc/usart_tx.md
Name: usart_tx

Overview:
- IO-mapped USART transmitter peripheral for the ATmega32A emulator.
- Uses the same write-enable/write-data interface as the timers and GPIO.
- Serialises bytes written to UDR onto a TXD pin as 8N1 frames, with a double-buffered data register.
- Exposes UCSRA/UCSRB/UBRRL for the IO read bus and raises UDRE/TXC interrupt requests for the control unit.

Parameters:
OVERSAMPLE, 16, clock ticks per bit per (UBRR+1); bit period = OVERSAMPLE*(UBRRL+1) clocks
UCSRA_RESET, 8'h20, UCSRA reset value (UDRE=1)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
write_data  input  8  data from memory map write path
UDR_write_enable  input  1  write UDR (IO 0x0C)
UCSRA_write_enable  input  1  write UCSRA (IO 0x0B)
UCSRB_write_enable  input  1  write UCSRB (IO 0x0A)
UBRRL_write_enable  input  1  write UBRRL (IO 0x09)
UCSRA_output  output  8  {0,TXC,UDRE,0,0,0,U2X,0}
UCSRB_output  output  8  {0,TXCIE,UDRIE,0,TXEN,0,0,0}; other bits are stored but have no function
UBRRL_output  output  8  baud divisor
TXD  output  1  serial output, idle high
udre_irq  output  1  UDRE & UDRIE
txc_irq  output  1  TXC & TXCIE
tx_busy  output  1  FSM not IDLE

Behaviour:
- Reset (async, immediate, also mid-frame): buffer=0, shift=0, UCSRA=UCSRA_RESET, UCSRB=0, UBRRL=0, TXD=1, tx_busy=0, irqs=0, FSM=IDLE, timers=0.
- UDR write with UDRE=1: buffer<=write_data, UDRE<=0 on that edge.
- UDR write with UDRE=0: ignored; buffer unchanged.
- UCSRA write: writing 1 to bit6 clears TXC. UDRE is read-only. U2X follows the Optional Feature rules. If TXC is set and cleared on the same edge, set wins.
- Bit timer: reloads with bit_period-1 at each bit boundary and counts down. UBRRL changes take effect from the next bit.
- FSM states:
  - IDLE: TXD=1. When TXEN=1 and UDRE=0: shift<=buffer, UDRE<=1, TXD<=0, go START. Start bit begins one clock after the UDR write edge.
  - START: one bit period, then DATA with bit index 0.
  - DATA: TXD=shift[0], LSB first. Shift right each bit period; after 8 bits go STOP.
  - STOP: TXD=1 for one bit period. At its end:
    - if TXEN=1 and UDRE=0, load the next byte and go to START on the same edge (back-to-back, no idle gap);
    - otherwise set TXC=1 and go IDLE.
- TXEN cleared mid-frame: the current frame completes and TXC is set. No pending byte starts; it stays in the buffer (UDRE=0) until TXEN returns.
- UDR writes during a frame are legal whenever UDRE=1 (double buffering).
- udre_irq and txc_irq are combinational from the register bits. TXC is cleared only by a UCSRA write or reset.

Optional Feature:
- Macro: USART_TX_U2X_EN.
- Defined: UCSRA bit1 (U2X) is writable. When U2X=1, bit period = (OVERSAMPLE/2)*(UBRRL+1). A U2X change takes effect from the next bit.
- Undefined: U2X ignores writes, reads 0, and the bit period is always OVERSAMPLE*(UBRRL+1).

Test Plan:
- Reset, no writes -> UCSRA_output=8'h20, TXD=1, irqs=0, tx_busy=0.
- UBRRL=0, UCSRB=8'h08, UDR=8'h55 -> TXD=0 one clock after the write edge. Then 1,0,1,0,1,0,1,0, then stop=1, each bit 16 clocks. TXC=1 exactly 160 clocks after the start bit began.
- Write 8'hA5 then 8'h3C while the first is in START -> UDRE 0→1 at frame start, then 0 after the second write. Frames are back-to-back: the second start bit immediately follows stop 1, with no idle clock. TXC is set only after the second stop.
- UDRE=0, write UDR=8'hFF -> ignored; the transmitted byte equals the earlier buffered value.
- UCSRB=8'h68 (TXCIE, UDRIE, TXEN) -> udre_irq=1 while idle. Send a byte -> txc_irq=1 at frame end. Write UCSRA=8'h40 -> TXC=0, txc_irq=0.
- Assert reset_n=0 mid-DATA with UBRRL=3 -> TXD=1 immediately and all registers at reset values. With USART_TX_U2X_EN, UCSRA=8'h02, UBRRL=3 -> bit period 32 clocks.
